// File: rtl/uart_bridge_pkg.sv
// Shared types and helpers for the UART bus-bridge frame receiver.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int ADDR_LSB             = 0;

  // Payload is {mode, data, addr}: one mode bit above the data and address fields.
  function automatic int calc_pkt_w(input int addr_w, input int data_w);
    return 1 + data_w + addr_w;
  endfunction

  function automatic int mode_pos(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int data_lsb(input int addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with full/empty flags and a registered head-of-queue output.
module sync_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNTW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = rd_data_q;

  // A pop frees a slot in the same cycle, so a push into a full queue still lands.
  always_comb begin
    pop_ok    = pop && !empty;
    push_ok   = push && (!full || pop_ok);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CNTW'(push_ok) - CNTW'(pop_ok);
    rd_data_d = rd_data_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (count_q > CNTW'(1)) begin
        rd_data_d = mem_q[rd_ptr_q + PW'(1)];
      end else if (push_ok) begin
        rd_data_d = wr_data;
      end
    end else if (push_ok && empty) begin
      rd_data_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: start bit, {mode,data,addr} LSB first, stop bit; frames queued for a bus master.
module uart_frame_rx
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic                  pkt_mode,
  output logic [ADDR_WIDTH-1:0] pkt_addr,
  output logic [DATA_WIDTH-1:0] pkt_data,
  output logic                  frame_err,
  output logic                  overrun_err
);

  localparam int PKT_W    = calc_pkt_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int MODE_POS = mode_pos(ADDR_WIDTH, DATA_WIDTH);
  localparam int DATA_LSB = data_lsb(ADDR_WIDTH);
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int BW       = $clog2(PKT_W);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PKT_W - 1);

  rx_state_t        state_q, state_d;
  logic             rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PKT_W-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             push, pop, fifo_full, fifo_empty;
  logic [PKT_W-1:0] head;

  assign pkt_valid   = !fifo_empty;
  assign pop         = pkt_valid && pkt_ready;
  assign pkt_mode    = head[MODE_POS];
  assign pkt_data    = head[DATA_LSB +: DATA_WIDTH];
  assign pkt_addr    = head[ADDR_LSB +: ADDR_WIDTH];
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;

  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + CW'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Mid-bit check rejects glitches shorter than half a bit.
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = rx_s_q;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            push      = 1'b1;
            overrun_d = fifo_full && !pop;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        clk_cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // The final data bit is written on the same edge it is sampled, so shift_q is complete in STOP.
  sync_fifo #(
    .WIDTH(PKT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_data(shift_q),
    .pop    (pop),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx at 16 clocks per bit, checked with immediate assertions.
module tb_uart_frame_rx;
  import uart_bridge_pkg::*;

  localparam int CPB = 16;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int PW  = 1 + DW + AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          pkt_ready = 1'b0;
  logic          pkt_valid, pkt_mode, frame_err, overrun_err;
  logic [AW-1:0] pkt_addr;
  logic [DW-1:0] pkt_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state, written only by the negedge monitor.
  logic [PW-1:0] obs_q[$];
  int            obs_cyc[$];
  int            valid_cycles = 0;
  int            fall_cnt = 0;
  int            fe_cnt = 0;
  int            ov_cnt = 0;
  int            cyc = 0;
  logic          prev_valid = 1'b0;

  // Expected frames, in acceptance order.
  logic [PW-1:0] exp_q[$];

  int s_obs, s_valid, s_fall, s_fe, s_ov;

  uart_frame_rx #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_mode   (pkt_mode),
    .pkt_addr   (pkt_addr),
    .pkt_data   (pkt_data),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (prev_valid && !pkt_valid) fall_cnt++;
    prev_valid = pkt_valid;
    if (pkt_valid) valid_cycles++;
    if (pkt_valid && pkt_ready) begin
      obs_q.push_back({pkt_mode, pkt_data, pkt_addr});
      obs_cyc.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic mode, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic stop_bit);
    logic [PW-1:0] pkt;
    pkt = {mode, data, addr};
    drive_bit(1'b0);
    for (int i = 0; i < PW; i++) drive_bit(pkt[i]);
    drive_bit(stop_bit);
  endtask

  // Starts a frame and applies a one-cycle reset at the start of payload bit abort_bit.
  task automatic send_aborted(input logic [PW-1:0] pkt, input int abort_bit);
    drive_bit(1'b0);
    for (int i = 0; i < abort_bit; i++) drive_bit(pkt[i]);
    rx  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_obs   = obs_q.size();
    s_valid = valid_cycles;
    s_fall  = fall_cnt;
    s_fe    = fe_cnt;
    s_ov    = ov_cnt;
  endtask

  initial begin
    @(posedge clk); #1;
    idle(3);
    rst = 1'b0;
    check("reset_valid", 32'(pkt_valid), 32'd0);
    check("reset_mode", 32'(pkt_mode), 32'd0);
    check("reset_addr", 32'(pkt_addr), 32'd0);
    check("reset_data", 32'(pkt_data), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_ovr", 32'(overrun_err), 32'd0);
    idle(5);

    // 1: write frame with the consumer always ready.
    snap();
    pkt_ready = 1'b1;
    exp_q.push_back({1'b1, 8'hA5, 12'h100});
    send_frame(1'b1, 12'h100, 8'hA5, 1'b1);
    idle(20);
    check("t1_count", 32'(obs_q.size() - s_obs), 32'd1);
    if (obs_q.size() > s_obs) check("t1_frame", 32'(obs_q[s_obs]), 32'(exp_q[0]));
    check("t1_valid_cycles", 32'(valid_cycles - s_valid), 32'd1);
    check("t1_ferr", 32'(fe_cnt - s_fe), 32'd0);
    check("t1_ovr", 32'(ov_cnt - s_ov), 32'd0);

    // 2: read frame with all-ones address.
    snap();
    exp_q.push_back({1'b0, 8'h00, 12'hFFF});
    send_frame(1'b0, 12'hFFF, 8'h00, 1'b1);
    idle(20);
    check("t2_count", 32'(obs_q.size() - s_obs), 32'd1);
    if (obs_q.size() > s_obs) check("t2_frame", 32'(obs_q[s_obs]), 32'(exp_q[1]));
    check("t2_errs", 32'((fe_cnt - s_fe) + (ov_cnt - s_ov)), 32'd0);

    // 3: backpressure; third back-to-back frame overruns the 2-deep queue.
    pkt_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h11, 12'h001});
    exp_q.push_back({1'b1, 8'h22, 12'h002});
    send_frame(1'b1, 12'h001, 8'h11, 1'b1);
    snap();
    check("t3_valid_after_f1", 32'(pkt_valid), 32'd1);
    send_frame(1'b1, 12'h002, 8'h22, 1'b1);
    send_frame(1'b1, 12'h003, 8'h33, 1'b1);
    idle(5);
    check("t3_valid_held", 32'(pkt_valid), 32'd1);
    check("t3_no_fall", 32'(fall_cnt - s_fall), 32'd0);
    check("t3_ovr_once", 32'(ov_cnt - s_ov), 32'd1);
    check("t3_no_pop_yet", 32'(obs_q.size() - s_obs), 32'd0);
    pkt_ready = 1'b1;
    idle(4);
    check("t3_pop_count", 32'(obs_q.size() - s_obs), 32'd2);
    if (obs_q.size() >= s_obs + 2) begin
      check("t3_first", 32'(obs_q[s_obs]), 32'(exp_q[2]));
      check("t3_second", 32'(obs_q[s_obs + 1]), 32'(exp_q[3]));
      check("t3_consecutive", 32'(obs_cyc[s_obs + 1] - obs_cyc[s_obs]), 32'd1);
    end
    check("t3_valid_low", 32'(pkt_valid), 32'd0);
    check("t3_ferr", 32'(fe_cnt - s_fe), 32'd0);

    // 4: stop bit low followed by a long break, then a good frame.
    snap();
    send_frame(1'b1, 12'h0F0, 8'h0F, 1'b0);
    rx = 1'b0;
    idle(40 * CPB);
    rx = 1'b1;
    idle(5);
    check("t4_ferr_once", 32'(fe_cnt - s_fe), 32'd1);
    check("t4_no_push", 32'(obs_q.size() - s_obs), 32'd0);
    check("t4_wait_state", 32'(dut.state_q), 32'(IDLE));
    exp_q.push_back({1'b0, 8'hC3, 12'h0AA});
    send_frame(1'b0, 12'h0AA, 8'hC3, 1'b1);
    idle(20);
    check("t4_good_count", 32'(obs_q.size() - s_obs), 32'd1);
    if (obs_q.size() > s_obs) check("t4_good_frame", 32'(obs_q[s_obs]), 32'(exp_q[4]));
    check("t4_ferr_total", 32'(fe_cnt - s_fe), 32'd1);
    check("t4_ovr", 32'(ov_cnt - s_ov), 32'd0);

    // 5: short glitch on the idle line.
    snap();
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(3 * CPB);
    check("t5_no_push", 32'(obs_q.size() - s_obs), 32'd0);
    check("t5_no_errs", 32'((fe_cnt - s_fe) + (ov_cnt - s_ov)), 32'd0);
    check("t5_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("t5_valid", 32'(pkt_valid), 32'd0);

    // 6: queued frame plus reset mid-frame; both dropped.
    pkt_ready = 1'b0;
    send_frame(1'b0, 12'h055, 8'h77, 1'b1);
    idle(3);
    check("t6_queued", 32'(pkt_valid), 32'd1);
    check("t6_head_addr", 32'(pkt_addr), 32'h055);
    send_aborted({1'b1, 8'h99, 12'h777}, 10);
    check("t6_rst_valid", 32'(pkt_valid), 32'd0);
    check("t6_rst_mode", 32'(pkt_mode), 32'd0);
    check("t6_rst_addr", 32'(pkt_addr), 32'd0);
    check("t6_rst_data", 32'(pkt_data), 32'd0);
    check("t6_rst_errs", 32'({frame_err, overrun_err}), 32'd0);
    check("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
    idle(20 * CPB);
    snap();
    pkt_ready = 1'b1;
    exp_q.push_back({1'b1, 8'h5A, 12'h123});
    send_frame(1'b1, 12'h123, 8'h5A, 1'b1);
    idle(20);
    check("t6_count", 32'(obs_q.size() - s_obs), 32'd1);
    if (obs_q.size() > s_obs) check("t6_frame", 32'(obs_q[s_obs]), 32'(exp_q[5]));
    check("t6_errs", 32'((fe_cnt - s_fe) + (ov_cnt - s_ov)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Parametrised UART frame receiver for the bus-bridge master. It deserialises one frame per transfer:
- start bit, then `PKT_W = 1 + DATA_WIDTH + ADDR_WIDTH` payload bits LSB first, then stop bit;
- payload packed `{mode, data, addr}`, with mode in the MSB.

Completed frames are queued in a small FIFO and presented on a valid/ready interface for the bus master. Over the fixed 12-bit/8-bit single-frame format, it adds configurable widths, mid-bit sampling with false-start rejection, framing-error and overrun detection, and output buffering.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: address field width.
- `DATA_WIDTH`, default 8: data field width.
- `CLKS_PER_BIT`, default 5208: clocks per UART bit (100 MHz, 19200 baud). Must be ≥ 4.
- `FIFO_DEPTH`, default 2: frame queue depth. Power of two, ≥ 2.

Ports:
- `clk`  in  1  sole clock. One clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous UART line, idle high.
- `pkt_valid`  out  1  FIFO head holds a frame.
- `pkt_ready`  in  1  consumer accepts the head frame.
- `pkt_mode`  out  1  head frame mode (1 = write, 0 = read).
- `pkt_addr`  out  ADDR_WIDTH  head frame address.
- `pkt_data`  out  DATA_WIDTH  head frame data.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: good frame dropped because the FIFO was full.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised `rx_s`.
- **Bit counter:** `bit_cnt` counts 0..PKT_W-1. The clock counter `clk_cnt` is $clog2(CLKS_PER_BIT) bits wide.
- **IDLE:** on `rx_s`==0, clear `clk_cnt` and go to START.
- **START:** when `clk_cnt` reaches CLKS_PER_BIT/2-1, sample `rx_s` (mid-bit).
  - Sample 1: false start, return to IDLE. No flags.
  - Sample 0: clear `clk_cnt` and go to DATA.
- **DATA:** every CLKS_PER_BIT clocks, sample `rx_s` into the shift register at index `bit_cnt`, so LSB arrives first.
  - After the PKT_W-th sample, go to STOP.
- **STOP:** after CLKS_PER_BIT clocks, sample `rx_s`.
  - Sample 1, FIFO not full: push `{mode,data,addr}` and go to IDLE.
  - Sample 1, FIFO full: drop the frame, pulse `overrun_err`, go to IDLE.
  - Sample 0: pulse `frame_err`, discard the frame, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s`==1, then go to IDLE. A break condition therefore yields exactly one `frame_err`.
- **Output side:** standard FIFO semantics.
  - Pop when `pkt_valid && pkt_ready`.
  - Output fields always show the head entry. They hold when `pkt_valid`==0.
- **Simultaneous push and pop with FIFO full:** the pop frees a slot, so the push succeeds and no overrun is flagged. With FIFO empty, the pushed frame appears on the next cycle.
- **Reset:**
  - All outputs 0, FIFO empty, state IDLE, counters 0.
  - Reset mid-frame abandons the frame silently. Receiving restarts at the next falling edge seen after reset.

## Timing
- Input latency: `rx` to `rx_s` is 2 cycles.
- Push happens on the cycle of the stop-bit mid-sample. `pkt_valid` rises on the following cycle, and fields are valid with it.
- `frame_err` and `overrun_err` assert on the cycle after the stop-bit sample, for one cycle.
- `pkt_valid` falls on the cycle after the pop of the last entry. Back-to-back pops sustain 1 frame/cycle.
- There is no combinational path from `pkt_ready` to `pkt_valid` or to the fields.
- Inter-frame gap: a new start bit is accepted from the cycle the state returns to IDLE, i.e. mid-stop-bit. Zero idle between frames is supported.
- Baud tolerance: ±2% on the full frame at the default PKT_W = 21.

## Structure
- Package `uart_bridge_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the `PKT_W` computation;
  - the default `CLKS_PER_BIT`;
  - the field-slice localparams (mode at [PKT_W-1], data at [ADDR_WIDTH +: DATA_WIDTH], addr at [0 +: ADDR_WIDTH]).
- One sub-module, `sync_fifo`, parametrised by WIDTH=PKT_W and DEPTH=FIFO_DEPTH, with full/empty flags and registered read data.
- The FSM, synchroniser and shift register stay in `uart_frame_rx`.

## Test plan
Run the bench with CLKS_PER_BIT=16 and defaults otherwise.
1. **Write frame:** mode=1, addr=0x100, data=0xA5, `pkt_ready`=1. Expect exactly one `pkt_valid` cycle with mode=1, addr=0x100, data=0xA5, and no error pulses.
2. **Read frame:** mode=0, addr=0xFFF, data=0x00. Expect `pkt_valid` with mode=0, addr=0xFFF, data=0x00.
3. **Backpressure and overrun:** hold `pkt_ready`=0 and send three back-to-back frames (addr 0x001/0x002/0x003).
   - Expect `pkt_valid` to stay high from frame 1, and `overrun_err` to pulse once at frame 3.
   - Then raise `pkt_ready`: expect addr 0x001 then 0x002 on consecutive cycles, then `pkt_valid`=0.
4. **Bad stop bit:** send a frame with the stop bit = 0, then hold `rx` low for 40 bit times. Expect a single `frame_err` pulse and no push. A following good frame (addr 0x0AA) is received correctly.
5. **Glitch:** drive a 5-cycle low glitch on idle `rx`. Expect no push and no error pulses; state returns to IDLE.
6. **Reset mid-frame:** assert `rst` for 1 cycle at bit 10 of a frame. Expect all outputs 0 and the frame dropped. The next full frame (mode=1, addr=0x123, data=0x5A) is received correctly.
